rob_multi_port: RTL and testbench
=================================

Name: rob_multi_port

Overview:
- Parametrised reorder buffer: successor to the single-issue ROB.
- 2-wide in-order dispatch with internally allocated tail pointer; FIN_PORTS completion ports; 2-wide in-order commit to ARF; full-pipeline flush.
- Sits between dispatch/rename and the architectural register file; exposes occupancy for dispatch stall.

Parameters:
ENTRY_NUM, 64, number of ROB entries, power of two, >= 4
ENTRY_SEL, 6, log2(ENTRY_NUM)
FIN_PORTS, 4, number of execution-completion ports
ADDR_LEN, 32, PC width
REG_SEL, 5, logical register index width

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
dp_req_i  input  2  dispatch request per slot; bit1 legal only with bit0
dp_pc_i  input  2*ADDR_LEN  slot0 PC in [ADDR_LEN-1:0], slot1 in upper half
dp_dstvalid_i  input  2  slot has destination register
dp_dst_i  input  2*REG_SEL  destination logical registers, packed as dp_pc_i
dp_ready_o  output  1  ROB can accept two entries this cycle
dp_addr1_o  output  ENTRY_SEL  entry assigned to slot0 (tail)
dp_addr2_o  output  ENTRY_SEL  entry assigned to slot1 (tail+1 mod ENTRY_NUM)
fin_valid_i  input  FIN_PORTS  completion strobe per port
fin_addr_i  input  FIN_PORTS*ENTRY_SEL  completed entry per port, port k at bits [k*ENTRY_SEL +: ENTRY_SEL]
flush_i  input  1  discard all uncommitted entries
commit_ptr_o  output  ENTRY_SEL  head pointer
commit_valid_o  output  2  entries head / head+1 commit this cycle
arfwe_o  output  2  ARF write enable per commit slot
dst_arf_o  output  2*REG_SEL  ARF destination per commit slot
commit_pc_o  output  2*ADDR_LEN  PC per commit slot
count_o  output  ENTRY_SEL+1  occupied entries
empty_o  output  1  count_o == 0

Behaviour:
- State: valid, finish, dstvalid bit vectors; pc and dst arrays; head and tail pointers; count. All pointer arithmetic is mod ENTRY_NUM; pointers wrap naturally.
- Reset: head=tail=0, count=0, valid=finish=0.
- Reset consequences: dp_ready_o=1, dp_addr1_o=0, dp_addr2_o=1, commit_valid_o=0, arfwe_o=0, commit_ptr_o=0, count_o=0, empty_o=1.
- Reset overrides flush_i and all other inputs.
- Array contents (pc, dst, dstvalid) are not reset.
- dp_ready_o = (ENTRY_NUM - count) >= 2.
  - Computed from registered count only; same-cycle commits do not raise it.
- Dispatch:
  - Accepted when dp_ready_o & dp_req_i[0] & ~flush_i.
  - Writes slot0 at tail, and slot1 at tail+1 if dp_req_i[1].
  - Sets valid=1, finish=0 and stores pc/dst/dstvalid.
  - tail advances by the number of slots accepted.
  - A request while not ready, or with dp_req_i=2'b10, is ignored.
- Completion: each fin_valid_i[k] sets finish at fin_addr_i[k]. This is ignored if the entry is not valid. Multiple ports hitting the same entry are harmless.
  - A same-cycle dispatch to the same entry wins (finish=0).
- Commit (combinational from registered state):
  - c0 = valid[head] & finish[head] & ~flush_i.
  - c1 = c0 & valid[head+1] & finish[head+1].
  - commit_valid_o = {c1, c0}.
  - arfwe_o[i] = commit_valid_o[i] & dstvalid of that entry.
  - dst_arf_o and commit_pc_o carry entry data regardless of valid.
  - A completion arriving this cycle is not bypassed; it commits at the earliest next cycle, i.e. 1-cycle finish-to-commit latency.
- Registered commit update: clear valid at committed entries; head += c0 + c1.
- count_next = count + accepted dispatches - commits. Simultaneous dispatch and commit are both applied.
- Flush (flush_i=1, no reset):
  - No dispatch and no commit that cycle.
  - All valid and finish bits cleared; tail <= head; count <= 0.
  - Completions in the flush cycle are discarded.
- Full: count == ENTRY_NUM reachable only via single-slot dispatch when count == ENTRY_NUM-2 is not possible. Because dp_ready_o requires 2 free entries, max count is ENTRY_NUM. count_o must never exceed ENTRY_NUM.

Test Plan:
- Reset then dual dispatch of PCs 0x100/0x104, dst 3/4 -> dp_addr1_o=0, dp_addr2_o=1, count_o=2. Finish both entries via ports 0 and 3 -> next cycle commit_valid_o=2'b11, arfwe_o=2'b11, dst_arf_o={4,3}, then count_o=0, commit_ptr_o=2.
- Out-of-order finish: dispatch entries 0..3, finish entry 2 then 1 -> no commit until entry 0 finishes. Then commit_valid_o=2'b11 (entries 0,1), next cycle c0 only (entry 2).
- Fill with 32 dual dispatches, no finishes (ENTRY_NUM=64) -> count_o=64, dp_ready_o=0. Further dp_req_i ignored (tail unchanged). Commit 2 -> dp_ready_o=1.
- Wrap-around: advance head/tail to 62, dual dispatch -> dp_addr1_o=62, dp_addr2_o=63; next dispatch gets 0/1. Commits cross 63->0 correctly with commit_ptr_o=0 afterwards.
- Flush with 5 entries valid, 2 finished at head, plus same-cycle dispatch and finish -> commit_valid_o=0 that cycle. Next cycle count_o=0, empty_o=1, tail equals head, stale finishes do not commit.
- dstvalid=0 entry committing -> commit_valid_o[0]=1, arfwe_o[0]=0. Completion to an invalid entry, then a later dispatch there -> finish=0, no spurious commit.

Source files
------------

// File: rtl/rob_multi_port.sv
// Reorder buffer: 2-wide in-order dispatch, FIN_PORTS completion ports,
// 2-wide in-order commit to the ARF, and full-pipeline flush.
module rob_multi_port #(
    parameter int unsigned ENTRY_NUM = 64,
    parameter int unsigned ENTRY_SEL = 6,
    parameter int unsigned FIN_PORTS = 4,
    parameter int unsigned ADDR_LEN  = 32,
    parameter int unsigned REG_SEL   = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [1:0]                     dp_req_i,
    input  logic [2*ADDR_LEN-1:0]          dp_pc_i,
    input  logic [1:0]                     dp_dstvalid_i,
    input  logic [2*REG_SEL-1:0]           dp_dst_i,
    output logic                           dp_ready_o,
    output logic [ENTRY_SEL-1:0]           dp_addr1_o,
    output logic [ENTRY_SEL-1:0]           dp_addr2_o,
    input  logic [FIN_PORTS-1:0]           fin_valid_i,
    input  logic [FIN_PORTS*ENTRY_SEL-1:0] fin_addr_i,
    input  logic                           flush_i,
    output logic [ENTRY_SEL-1:0]           commit_ptr_o,
    output logic [1:0]                     commit_valid_o,
    output logic [1:0]                     arfwe_o,
    output logic [2*REG_SEL-1:0]           dst_arf_o,
    output logic [2*ADDR_LEN-1:0]          commit_pc_o,
    output logic [ENTRY_SEL:0]             count_o,
    output logic                           empty_o
);

    localparam int unsigned CNT_W = ENTRY_SEL + 1;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(ENTRY_NUM - 2);

    logic [ENTRY_NUM-1:0] r_valid;
    logic [ENTRY_NUM-1:0] r_finish;
    logic [ENTRY_NUM-1:0] r_dstvalid;
    logic [ADDR_LEN-1:0]  r_pc  [ENTRY_NUM];
    logic [REG_SEL-1:0]   r_dst [ENTRY_NUM];
    logic [ENTRY_SEL-1:0] r_head;
    logic [ENTRY_SEL-1:0] r_tail;
    logic [CNT_W-1:0]     r_count;

    logic [ENTRY_SEL-1:0] w_head1;
    logic [ENTRY_SEL-1:0] w_tail1;
    logic                 w_dp0;
    logic                 w_dp1;
    logic                 w_c0;
    logic                 w_c1;
    logic [ENTRY_NUM-1:0] w_valid_n;
    logic [ENTRY_NUM-1:0] w_finish_n;

    assign w_head1 = r_head + ENTRY_SEL'(1);
    assign w_tail1 = r_tail + ENTRY_SEL'(1);

    // Readiness looks only at registered occupancy; same-cycle commits do not help.
    assign dp_ready_o = (r_count <= READY_MAX);
    assign w_dp0      = dp_ready_o & dp_req_i[0] & ~flush_i;
    assign w_dp1      = w_dp0 & dp_req_i[1];

    assign w_c0 = r_valid[r_head] & r_finish[r_head] & ~flush_i;
    assign w_c1 = w_c0 & r_valid[w_head1] & r_finish[w_head1];

    assign dp_addr1_o     = r_tail;
    assign dp_addr2_o     = w_tail1;
    assign commit_ptr_o   = r_head;
    assign commit_valid_o = {w_c1, w_c0};
    assign arfwe_o        = {w_c1 & r_dstvalid[w_head1], w_c0 & r_dstvalid[r_head]};
    assign dst_arf_o      = {r_dst[w_head1], r_dst[r_head]};
    assign commit_pc_o    = {r_pc[w_head1], r_pc[r_head]};
    assign count_o        = r_count;
    assign empty_o        = (r_count == '0);

    // Next valid/finish vectors: completions, then commit clears, then dispatch (dispatch wins).
    always_comb begin
        w_valid_n  = r_valid;
        w_finish_n = r_finish;
        for (int k = 0; k < int'(FIN_PORTS); k++) begin
            if (fin_valid_i[k] && r_valid[fin_addr_i[k*ENTRY_SEL +: ENTRY_SEL]]) begin
                w_finish_n[fin_addr_i[k*ENTRY_SEL +: ENTRY_SEL]] = 1'b1;
            end
        end
        if (w_c0) begin
            w_valid_n[r_head]  = 1'b0;
            w_finish_n[r_head] = 1'b0;
        end
        if (w_c1) begin
            w_valid_n[w_head1]  = 1'b0;
            w_finish_n[w_head1] = 1'b0;
        end
        if (w_dp0) begin
            w_valid_n[r_tail]  = 1'b1;
            w_finish_n[r_tail] = 1'b0;
        end
        if (w_dp1) begin
            w_valid_n[w_tail1]  = 1'b1;
            w_finish_n[w_tail1] = 1'b0;
        end
        if (flush_i) begin
            w_valid_n  = '0;
            w_finish_n = '0;
        end
    end

    // Control state: pointers, occupancy and status bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            r_finish <= '0;
        end else if (flush_i) begin
            r_valid  <= '0;
            r_finish <= '0;
            r_tail   <= r_head;
            r_count  <= '0;
        end else begin
            r_valid  <= w_valid_n;
            r_finish <= w_finish_n;
            r_head   <= r_head + ENTRY_SEL'(w_c0) + ENTRY_SEL'(w_c1);
            r_tail   <= r_tail + ENTRY_SEL'(w_dp0) + ENTRY_SEL'(w_dp1);
            r_count  <= r_count + CNT_W'(w_dp0) + CNT_W'(w_dp1)
                                - CNT_W'(w_c0) - CNT_W'(w_c1);
        end
    end

    // Entry payload storage; contents are don't-care until dispatched.
    always_ff @(posedge clk) begin
        if (!reset && w_dp0) begin
            r_pc[r_tail]       <= dp_pc_i[ADDR_LEN-1:0];
            r_dst[r_tail]      <= dp_dst_i[REG_SEL-1:0];
            r_dstvalid[r_tail] <= dp_dstvalid_i[0];
        end
        if (!reset && w_dp1) begin
            r_pc[w_tail1]       <= dp_pc_i[2*ADDR_LEN-1:ADDR_LEN];
            r_dst[w_tail1]      <= dp_dst_i[2*REG_SEL-1:REG_SEL];
            r_dstvalid[w_tail1] <= dp_dstvalid_i[1];
        end
    end

endmodule

// File: tb/tb_rob_multi_port.sv
// Bench for rob_multi_port: directed vector table, directed corner sequences,
// and random traffic against an in-order queue model of the ROB.
module tb_rob_multi_port;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  dp_req_i;
    logic [63:0] dp_pc_i;
    logic [1:0]  dp_dstvalid_i;
    logic [9:0]  dp_dst_i;
    logic        dp_ready_o;
    logic [5:0]  dp_addr1_o;
    logic [5:0]  dp_addr2_o;
    logic [3:0]  fin_valid_i;
    logic [23:0] fin_addr_i;
    logic        flush_i;
    logic [5:0]  commit_ptr_o;
    logic [1:0]  commit_valid_o;
    logic [1:0]  arfwe_o;
    logic [9:0]  dst_arf_o;
    logic [63:0] commit_pc_o;
    logic [6:0]  count_o;
    logic        empty_o;

    rob_multi_port dut (
        .clk(clk), .reset(reset),
        .dp_req_i(dp_req_i), .dp_pc_i(dp_pc_i), .dp_dstvalid_i(dp_dstvalid_i),
        .dp_dst_i(dp_dst_i), .dp_ready_o(dp_ready_o),
        .dp_addr1_o(dp_addr1_o), .dp_addr2_o(dp_addr2_o),
        .fin_valid_i(fin_valid_i), .fin_addr_i(fin_addr_i), .flush_i(flush_i),
        .commit_ptr_o(commit_ptr_o), .commit_valid_o(commit_valid_o),
        .arfwe_o(arfwe_o), .dst_arf_o(dst_arf_o), .commit_pc_o(commit_pc_o),
        .count_o(count_o), .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          addr;
        logic [31:0] pc;
        logic [4:0]  dst;
        bit          dv;
        bit          fin;
    } ent_t;

    ent_t q[$];
    int   m_head;
    int   m_tail;

    typedef struct {
        logic [1:0]  req;
        logic [63:0] pc;
        logic [1:0]  dv;
        logic [9:0]  dst;
        logic [3:0]  fv;
        logic [23:0] fa;
        logic        fl;
        logic        e_ready;
        logic [5:0]  e_a1;
        logic [5:0]  e_cptr;
        logic [6:0]  e_cnt;
        logic [1:0]  e_cv;
        logic [1:0]  e_we;
        logic [9:0]  e_dst;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] fa_pack(input int a0, input int a1, input int a2, input int a3);
        return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
    endfunction

    task automatic drive(input logic [1:0] req, input logic [63:0] pc, input logic [1:0] dv,
                         input logic [9:0] dst, input logic [3:0] fv, input logic [23:0] fa,
                         input logic fl);
        dp_req_i = req; dp_pc_i = pc; dp_dstvalid_i = dv; dp_dst_i = dst;
        fin_valid_i = fv; fin_addr_i = fa; flush_i = fl;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(2'b00, 64'h0, 2'b00, 10'h0, 4'h0, 24'h0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(2'b00, 64'h0, 2'b00, 10'h0, 4'h0, 24'h0, 1'b0);
        q.delete();
        m_head = 0;
        m_tail = 0;
    endtask

    // One cycle of stimulus, checked against the queue model, then model advanced.
    task automatic step(input logic [1:0] req, input logic [63:0] pc, input logic [1:0] dv,
                        input logic [9:0] dst, input logic [3:0] fv, input logic [23:0] fa,
                        input logic fl);
        bit rdy, c0, c1;
        int sz;
        @(negedge clk);
        drive(req, pc, dv, dst, fv, fa, fl);
        #1;
        sz  = q.size();
        rdy = (N - sz) >= 2;
        c0  = !fl && sz > 0 && q[0].fin;
        c1  = c0 && sz > 1 && q[1].fin;
        chk("dp_ready", 64'(dp_ready_o), 64'(rdy));
        chk("dp_addr1", 64'(dp_addr1_o), 64'(m_tail % N));
        chk("dp_addr2", 64'(dp_addr2_o), 64'((m_tail + 1) % N));
        chk("commit_ptr", 64'(commit_ptr_o), 64'(m_head));
        chk("count", 64'(count_o), 64'(sz));
        chk("empty", 64'(empty_o), 64'(sz == 0));
        chk("commit_valid", 64'(commit_valid_o), 64'({c1, c0}));
        chk("arfwe", 64'(arfwe_o), 64'({c1 && q[1].dv, c0 && q[0].dv}));
        if (c0) begin
            chk("dst0", 64'(dst_arf_o[4:0]), 64'(q[0].dst));
            chk("pc0", 64'(commit_pc_o[31:0]), 64'(q[0].pc));
        end
        if (c1) begin
            chk("dst1", 64'(dst_arf_o[9:5]), 64'(q[1].dst));
            chk("pc1", 64'(commit_pc_o[63:32]), 64'(q[1].pc));
        end
        if (fl) begin
            q.delete();
            m_tail = m_head;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (fv[k]) begin
                    for (int j = 0; j < q.size(); j++)
                        if (q[j].addr == int'(fa[k*6 +: 6])) q[j].fin = 1'b1;
                end
            end
            if (c0) begin q.delete(0); m_head = (m_head + 1) % N; end
            if (c1) begin q.delete(0); m_head = (m_head + 1) % N; end
            if (rdy && req[0]) begin
                q.push_back('{m_tail, pc[31:0], dst[4:0], dv[0], 1'b0});
                m_tail = (m_tail + 1) % N;
                if (req[1]) begin
                    q.push_back('{m_tail, pc[63:32], dst[9:5], dv[1], 1'b0});
                    m_tail = (m_tail + 1) % N;
                end
            end
        end
        @(posedge clk);
        #1;
        drive(2'b00, 64'h0, 2'b00, 10'h0, 4'h0, 24'h0, 1'b0);
    endtask

    task automatic idle();
        step(2'b00, 64'h0, 2'b00, 10'h0, 4'h0, 24'h0, 1'b0);
    endtask

    initial begin
        int t;
        logic [1:0]  r_req;
        logic [3:0]  r_fv;
        int          fa_a [4];

        // Directed vectors: inputs applied before the edge, outputs expected just before it.
        tbl[0]  = '{2'b11, {32'h104, 32'h100}, 2'b11, {5'd4, 5'd3}, 4'b0000, 24'h0, 1'b0,
                    1'b1, 6'd0, 6'd0, 7'd0, 2'b00, 2'b00, 10'h0};
        tbl[1]  = '{2'b00, 64'h0, 2'b00, 10'h0, 4'b1001, fa_pack(0, 0, 0, 1), 1'b0,
                    1'b1, 6'd2, 6'd0, 7'd2, 2'b00, 2'b00, 10'h0};
        tbl[2]  = '{2'b00, 64'h0, 2'b00, 10'h0, 4'b0000, 24'h0, 1'b0,
                    1'b1, 6'd2, 6'd0, 7'd2, 2'b11, 2'b11, {5'd4, 5'd3}};
        tbl[3]  = '{2'b00, 64'h0, 2'b00, 10'h0, 4'b0000, 24'h0, 1'b0,
                    1'b1, 6'd2, 6'd2, 7'd0, 2'b00, 2'b00, 10'h0};
        tbl[4]  = '{2'b01, 64'h200, 2'b00, 10'd7, 4'b0000, 24'h0, 1'b0,
                    1'b1, 6'd2, 6'd2, 7'd0, 2'b00, 2'b00, 10'h0};
        tbl[5]  = '{2'b00, 64'h0, 2'b00, 10'h0, 4'b0010, fa_pack(0, 2, 0, 0), 1'b0,
                    1'b1, 6'd3, 6'd2, 7'd1, 2'b00, 2'b00, 10'h0};
        tbl[6]  = '{2'b00, 64'h0, 2'b00, 10'h0, 4'b0000, 24'h0, 1'b0,
                    1'b1, 6'd3, 6'd2, 7'd1, 2'b01, 2'b00, 10'd7};
        tbl[7]  = '{2'b00, 64'h0, 2'b00, 10'h0, 4'b0000, 24'h0, 1'b0,
                    1'b1, 6'd3, 6'd3, 7'd0, 2'b00, 2'b00, 10'h0};
        tbl[8]  = '{2'b00, 64'h0, 2'b00, 10'h0, 4'b0100, fa_pack(0, 0, 3, 0), 1'b0,
                    1'b1, 6'd3, 6'd3, 7'd0, 2'b00, 2'b00, 10'h0};
        tbl[9]  = '{2'b01, 64'h300, 2'b01, 10'd9, 4'b0000, 24'h0, 1'b0,
                    1'b1, 6'd3, 6'd3, 7'd0, 2'b00, 2'b00, 10'h0};
        tbl[10] = '{2'b00, 64'h0, 2'b00, 10'h0, 4'b0000, 24'h0, 1'b0,
                    1'b1, 6'd4, 6'd3, 7'd1, 2'b00, 2'b00, 10'h0};
        tbl[11] = '{2'b01, 64'h304, 2'b01, 10'd10, 4'b0011, fa_pack(3, 4, 0, 0), 1'b0,
                    1'b1, 6'd4, 6'd3, 7'd1, 2'b00, 2'b00, 10'h0};
        tbl[12] = '{2'b00, 64'h0, 2'b00, 10'h0, 4'b0000, 24'h0, 1'b0,
                    1'b1, 6'd5, 6'd3, 7'd2, 2'b01, 2'b01, 10'd9};
        tbl[13] = '{2'b00, 64'h0, 2'b00, 10'h0, 4'b0000, 24'h0, 1'b0,
                    1'b1, 6'd5, 6'd4, 7'd1, 2'b00, 2'b00, 10'h0};
        tbl[14] = '{2'b11, 64'h0, 2'b11, 10'h0, 4'b0001, fa_pack(4, 0, 0, 0), 1'b1,
                    1'b1, 6'd5, 6'd4, 7'd1, 2'b00, 2'b00, 10'h0};
        tbl[15] = '{2'b00, 64'h0, 2'b00, 10'h0, 4'b0000, 24'h0, 1'b0,
                    1'b1, 6'd4, 6'd4, 7'd0, 2'b00, 2'b00, 10'h0};

        do_reset();
        #1;
        chk("rst_ready", 64'(dp_ready_o), 64'd1);
        chk("rst_addr1", 64'(dp_addr1_o), 64'd0);
        chk("rst_addr2", 64'(dp_addr2_o), 64'd1);
        chk("rst_cv", 64'(commit_valid_o), 64'd0);
        chk("rst_we", 64'(arfwe_o), 64'd0);
        chk("rst_cptr", 64'(commit_ptr_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_empty", 64'(empty_o), 64'd1);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(tbl[i].req, tbl[i].pc, tbl[i].dv, tbl[i].dst, tbl[i].fv, tbl[i].fa, tbl[i].fl);
            #1;
            chk($sformatf("v%0d_ready", i), 64'(dp_ready_o), 64'(tbl[i].e_ready));
            chk($sformatf("v%0d_addr1", i), 64'(dp_addr1_o), 64'(tbl[i].e_a1));
            chk($sformatf("v%0d_cptr", i), 64'(commit_ptr_o), 64'(tbl[i].e_cptr));
            chk($sformatf("v%0d_count", i), 64'(count_o), 64'(tbl[i].e_cnt));
            chk($sformatf("v%0d_cv", i), 64'(commit_valid_o), 64'(tbl[i].e_cv));
            chk($sformatf("v%0d_we", i), 64'(arfwe_o), 64'(tbl[i].e_we));
            if (tbl[i].e_cv[0]) chk($sformatf("v%0d_dst0", i), 64'(dst_arf_o[4:0]), 64'(tbl[i].e_dst[4:0]));
            if (tbl[i].e_cv[1]) chk($sformatf("v%0d_dst1", i), 64'(dst_arf_o[9:5]), 64'(tbl[i].e_dst[9:5]));
            @(posedge clk);
        end

        // Out-of-order finish: 2 then 1, nothing commits until 0 finishes.
        do_reset();
        step(2'b11, {32'h10, 32'h0C}, 2'b11, {5'd1, 5'd2}, 4'h0, 24'h0, 1'b0);
        step(2'b11, {32'h18, 32'h14}, 2'b11, {5'd3, 5'd4}, 4'h0, 24'h0, 1'b0);
        step(2'b00, 64'h0, 2'b00, 10'h0, 4'b0001, fa_pack(2, 0, 0, 0), 1'b0);
        step(2'b00, 64'h0, 2'b00, 10'h0, 4'b0100, fa_pack(0, 0, 1, 0), 1'b0);
        idle();
        chk("ooo_hold", 64'(commit_valid_o), 64'd0);
        step(2'b00, 64'h0, 2'b00, 10'h0, 4'b1000, fa_pack(0, 0, 0, 0), 1'b0);
        #1;
        chk("ooo_c01", 64'(commit_valid_o), 64'b11);
        idle();
        #1;
        chk("ooo_c2", 64'(commit_valid_o), 64'b01);
        idle();

        // Fill to 64 entries, check the stall, then free two.
        do_reset();
        for (int i = 0; i < 32; i++)
            step(2'b11, {$urandom, $urandom}, 2'b11, 10'($urandom), 4'h0, 24'h0, 1'b0);
        chk("full_count", 64'(count_o), 64'd64);
        chk("full_ready", 64'(dp_ready_o), 64'd0);
        step(2'b11, 64'h1234, 2'b11, 10'h3, 4'h0, 24'h0, 1'b0);
        chk("full_tail", 64'(dp_addr1_o), 64'd0);
        chk("full_count2", 64'(count_o), 64'd64);
        step(2'b00, 64'h0, 2'b00, 10'h0, 4'b1001, fa_pack(0, 0, 0, 1), 1'b0);
        idle();
        chk("free_ready", 64'(dp_ready_o), 64'd1);

        // Flush with finished head entries plus same-cycle dispatch and finish.
        step(2'b00, 64'h0, 2'b00, 10'h0, 4'b0011, fa_pack(2, 3, 0, 0), 1'b0);
        step(2'b11, 64'h55, 2'b11, 10'h5, 4'b0001, fa_pack(4, 0, 0, 0), 1'b1);
        chk("flush_count", 64'(count_o), 64'd0);
        chk("flush_empty", 64'(empty_o), 64'd1);
        chk("flush_tail", 64'(dp_addr1_o), 64'd2);
        chk("flush_nocommit", 64'(commit_valid_o), 64'd0);
        idle();

        // Wrap-around: walk head/tail to 62, then cross 63 -> 0.
        t = 2;
        for (int i = 0; i < 30; i++) begin
            step(2'b11, {$urandom, $urandom}, 2'($urandom), 10'($urandom), 4'h0, 24'h0, 1'b0);
            step(2'b00, 64'h0, 2'b00, 10'h0, 4'b0101, fa_pack(t, 0, t + 1, 0), 1'b0);
            idle();
            t = t + 2;
        end
        chk("wrap_a1", 64'(dp_addr1_o), 64'd62);
        chk("wrap_a2", 64'(dp_addr2_o), 64'd63);
        step(2'b11, {32'hA4, 32'hA0}, 2'b11, {5'd11, 5'd10}, 4'h0, 24'h0, 1'b0);
        chk("wrap_a1b", 64'(dp_addr1_o), 64'd0);
        step(2'b11, {32'hAC, 32'hA8}, 2'b11, {5'd13, 5'd12}, 4'b1111, fa_pack(62, 63, 62, 63), 1'b0);
        idle();
        chk("wrap_cptr", 64'(commit_ptr_o), 64'd0);
        step(2'b00, 64'h0, 2'b00, 10'h0, 4'b0011, fa_pack(0, 1, 0, 0), 1'b0);
        idle();
        chk("wrap_cptr2", 64'(commit_ptr_o), 64'd2);

        // Random traffic against the queue model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            r_req = 2'($urandom_range(0, 3));
            r_fv  = 4'($urandom);
            for (int k = 0; k < 4; k++) begin
                if (q.size() > 0 && $urandom_range(0, 3) != 0)
                    fa_a[k] = q[$urandom_range(0, q.size() - 1)].addr;
                else
                    fa_a[k] = $urandom_range(0, N - 1);
            end
            step(r_req, {$urandom, $urandom}, 2'($urandom), 10'($urandom), r_fv,
                 fa_pack(fa_a[0], fa_a[1], fa_a[2], fa_a[3]), $urandom_range(0, 99) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
